// File: rtl/branch_resolver.sv
// Conditional branch resolver: evaluates a condition code against the flags and
// returns the next PC through a one-entry valid/ready output stage.
// Flag bit order on alu_flags/cur_flags: [3]=Z, [2]=N, [1]=V, [0]=C.
module branch_resolver #(
  parameter int unsigned INSN_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flags_we,
  input  logic [3:0]  alu_flags,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [3:0]  br_cond,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_taken,
  output logic [31:0] res_target,
  output logic [3:0]  cur_flags
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t      r_state;
  logic [3:0]  r_flags;
  logic        r_taken;
  logic [31:0] r_target;

  logic [3:0]  w_flags;
  logic        w_z, w_n, w_v, w_c;
  logic        w_taken;
  logic        w_accept;
  logic [31:0] w_target;

  assign res_valid  = (r_state == S_FULL);
  assign res_taken  = r_taken;
  assign res_target = r_target;
  assign cur_flags  = r_flags;
  assign br_ready   = !res_valid || res_ready;
  assign w_accept   = br_valid && br_ready;

  // Same-cycle ALU flags bypass the flags register when it is being written.
  assign w_flags = flags_we ? alu_flags : r_flags;
  assign w_z = w_flags[3];
  assign w_n = w_flags[2];
  assign w_v = w_flags[1];
  assign w_c = w_flags[0];

  always_comb begin
    w_taken = 1'b0;
    unique case (br_cond)
      4'd0:  w_taken = w_z;
      4'd1:  w_taken = !w_z;
      4'd2:  w_taken = w_c;
      4'd3:  w_taken = !w_c;
      4'd4:  w_taken = w_n;
      4'd5:  w_taken = !w_n;
      4'd6:  w_taken = w_v;
      4'd7:  w_taken = !w_v;
      4'd8:  w_taken = w_c && !w_z;
      4'd9:  w_taken = !w_c || w_z;
      4'd10: w_taken = (w_n == w_v);
      4'd11: w_taken = (w_n != w_v);
      4'd12: w_taken = !w_z && (w_n == w_v);
      4'd13: w_taken = w_z || (w_n != w_v);
      4'd14: w_taken = 1'b1;
      4'd15: w_taken = 1'b0;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_target = br_pc + (w_taken ? br_offset : 32'(INSN_BYTES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_EMPTY;
      r_flags  <= '0;
      r_taken  <= 1'b0;
      r_target <= '0;
    end else begin
      if (flags_we) r_flags <= alu_flags;
      if (w_accept) begin
        r_taken  <= w_taken;
        r_target <= w_target;
      end
      unique case (r_state)
        S_EMPTY: if (w_accept) r_state <= S_FULL;
        S_FULL:  if (res_ready && !w_accept) r_state <= S_EMPTY;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flags_we;
  logic [3:0]  alu_flags;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic [31:0] res_target;
  logic [3:0]  cur_flags;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolver #(.INSN_BYTES(4)) dut (
    .clk(clk), .reset_n(reset_n), .flags_we(flags_we), .alu_flags(alu_flags),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_pc(br_pc),
    .br_offset(br_offset), .res_valid(res_valid), .res_ready(res_ready),
    .res_taken(res_taken), .res_target(res_target), .cur_flags(cur_flags)
  );

  always #5 clk = ~clk;

  // Flags packed as {Z,N,V,C}; condition table written straight from the code list.
  function automatic logic exp_taken(input logic [3:0] c, input logic [3:0] f);
    logic z, n, v, cy;
    z = f[3]; n = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return cy;
      4'd3:  return ~cy;
      4'd4:  return n;
      4'd5:  return ~n;
      4'd6:  return v;
      4'd7:  return ~v;
      4'd8:  return cy & ~z;
      4'd9:  return ~cy | z;
      4'd10: return ~(n ^ v);
      4'd11: return n ^ v;
      4'd12: return ~z & ~(n ^ v);
      4'd13: return z | (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] off);
    br_valid = 1'b1; br_cond = c; br_pc = pc; br_offset = off;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; flags_we = 0; alu_flags = '0; br_valid = 0; br_cond = '0;
    br_pc = '0; br_offset = '0; res_ready = 1'b1;
    #2;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", res_valid); end
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got %b exp 0", res_taken); end
    n_checks++; if (res_target !== 32'h0) begin n_fail++; $display("FAIL reset_target got %h exp 0", res_target); end
    n_checks++; if (cur_flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %h exp 0", cur_flags); end
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", br_ready); end
    #10 reset_n = 1'b1;
    tick;
  endtask

  task automatic test_always;
    drive_req(4'd14, 32'h100, 32'h20);
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL al_ready got %b exp 1", br_ready); end
    tick;
    br_valid = 0;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL al_valid got %b exp 1", res_valid); end
    n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL al_taken got %b exp 1", res_taken); end
    n_checks++; if (res_target !== 32'h120) begin n_fail++; $display("FAIL al_target got %h exp 00000120", res_target); end
    tick;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL al_drain got %b exp 0", res_valid); end
  endtask

  task automatic test_forward;
    // EQ with Z forwarded from the ALU while the register still holds 0
    flags_we = 1; alu_flags = 4'b1000;
    drive_req(4'd0, 32'h200, 32'hFFFF_FFF8);
    tick;
    flags_we = 0; br_valid = 0;
    n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL fwd_taken got %b exp 1", res_taken); end
    n_checks++; if (res_target !== 32'h1F8) begin n_fail++; $display("FAIL fwd_target got %h exp 000001f8", res_target); end
    n_checks++; if (cur_flags !== 4'b1000) begin n_fail++; $display("FAIL fwd_flags got %h exp 8", cur_flags); end
    // register holds Z=1, ALU presents Z=0 with write: NE must see the forwarded Z=0
    flags_we = 1; alu_flags = 4'b0000;
    drive_req(4'd1, 32'h300, 32'h40);
    tick;
    flags_we = 0; br_valid = 0;
    n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL fwd_ne_taken got %b exp 1", res_taken); end
    n_checks++; if (res_target !== 32'h340) begin n_fail++; $display("FAIL fwd_ne_target got %h exp 00000340", res_target); end
    // no write: ALU flags ignored, register (all zero) used
    alu_flags = 4'b1000;
    drive_req(4'd0, 32'h10, 32'h40);
    tick;
    br_valid = 0;
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL nofwd_taken got %b exp 0", res_taken); end
    n_checks++; if (res_target !== 32'h14) begin n_fail++; $display("FAIL nofwd_target got %h exp 00000014", res_target); end
    n_checks++; if (cur_flags !== 4'b0000) begin n_fail++; $display("FAIL nofwd_flags got %h exp 0", cur_flags); end
    tick;
  endtask

  task automatic test_wrap;
    flags_we = 1; alu_flags = 4'b0100;
    tick;
    flags_we = 0; alu_flags = '0;
    drive_req(4'd10, 32'hFFFF_FFFC, 32'h40);
    tick;
    br_valid = 0;
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL wrap_taken got %b exp 0", res_taken); end
    n_checks++; if (res_target !== 32'h0) begin n_fail++; $display("FAIL wrap_target got %h exp 00000000", res_target); end
    drive_req(4'd14, 32'hFFFF_FFF0, 32'h20);
    tick;
    br_valid = 0;
    n_checks++; if (res_target !== 32'h10) begin n_fail++; $display("FAIL wrap_taken_target got %h exp 00000010", res_target); end
    tick;
  endtask

  task automatic test_backpressure;
    res_ready = 0;
    drive_req(4'd14, 32'h300, 32'h4);
    tick;
    drive_req(4'd15, 32'h400, 32'h10);
    for (int i = 0; i < 3; i++) begin
      flags_we = 1; alu_flags = 4'(i + 9);
      #1;
      n_checks++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, br_ready); end
      n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, res_valid); end
      n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL bp_taken[%0d] got %b exp 1", i, res_taken); end
      n_checks++; if (res_target !== 32'h304) begin n_fail++; $display("FAIL bp_target[%0d] got %h exp 00000304", i, res_target); end
      tick;
    end
    flags_we = 0;
    res_ready = 1;
    #1;
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", br_ready); end
    tick;
    br_valid = 0;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got %b exp 1", res_valid); end
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL bp_next_taken got %b exp 0", res_taken); end
    n_checks++; if (res_target !== 32'h404) begin n_fail++; $display("FAIL bp_next_target got %h exp 00000404", res_target); end
    tick;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", res_valid); end
  endtask

  task automatic test_back_to_back;
    flags_we = 1; alu_flags = 4'b0001;
    tick;
    flags_we = 0;
    drive_req(4'd8, 32'h500, 32'h10);
    tick;
    n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_hi_taken got %b exp 1", res_taken); end
    n_checks++; if (res_target !== 32'h510) begin n_fail++; $display("FAIL b2b_hi_target got %h exp 00000510", res_target); end
    drive_req(4'd9, 32'h600, 32'h10);
    tick;
    br_valid = 0;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ls_valid got %b exp 1", res_valid); end
    n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL b2b_ls_taken got %b exp 0", res_taken); end
    n_checks++; if (res_target !== 32'h604) begin n_fail++; $display("FAIL b2b_ls_target got %h exp 00000604", res_target); end
    tick;
  endtask

  task automatic test_cond_table;
    logic [3:0] pats [7];
    logic       e;
    pats = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0110, 4'b1111};
    for (int p = 0; p < 7; p++) begin
      for (int c = 0; c < 16; c++) begin
        flags_we = 1; alu_flags = pats[p];
        drive_req(4'(c), 32'h1000, 32'h80);
        e = exp_taken(4'(c), pats[p]);
        tick;
        n_checks++;
        if (res_taken !== e)
          begin n_fail++; $display("FAIL cond[%0d] flags=%b got %b exp %b", c, pats[p], res_taken, e); end
        n_checks++;
        if (res_target !== (e ? 32'h1080 : 32'h1004))
          begin n_fail++; $display("FAIL cond_target[%0d] flags=%b got %h exp %h", c, pats[p], res_target, e ? 32'h1080 : 32'h1004); end
      end
    end
    flags_we = 0; br_valid = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    res_ready = 0;
    flags_we = 1; alu_flags = 4'b1010;
    drive_req(4'd14, 32'h700, 32'h8);
    tick;
    flags_we = 0; br_valid = 0;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got %b exp 1", res_valid); end
    reset_n = 0;
    #1;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", res_valid); end
    n_checks++; if (cur_flags !== 4'h0) begin n_fail++; $display("FAIL rmid_flags got %h exp 0", cur_flags); end
    n_checks++; if (res_target !== 32'h0) begin n_fail++; $display("FAIL rmid_target got %h exp 0", res_target); end
    #2 reset_n = 1;
    res_ready = 1;
    tick;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_resp got %b exp 0", res_valid); end
    drive_req(4'd14, 32'h800, 32'h30);
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b exp 1", br_ready); end
    tick;
    br_valid = 0;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_post_valid got %b exp 1", res_valid); end
    n_checks++; if (res_target !== 32'h830) begin n_fail++; $display("FAIL rmid_post_target got %h exp 00000830", res_target); end
    tick;
  endtask

  initial begin
    test_reset;
    test_always;
    test_forward;
    test_wrap;
    test_backpressure;
    test_back_to_back;
    test_cond_table;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have one parameter: INSN_BYTES, default 4, the sequential-PC increment in bytes.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: flags_we  input  1  capture alu_flags into the flags register this cycle.
REQ-006 Port: alu_flags  input  flags (h2bp)  zero/negative/overflow/carry produced by the ALU.
REQ-007 Port: br_valid  input  1  branch request valid.
REQ-008 Port: br_ready  output  1  block accepts the request this cycle.
REQ-009 Port: br_cond  input  4  condition code (encoding in REQ-014).
REQ-010 Port: br_pc  input  32  PC of the branch.
REQ-011 Port: br_offset  input  32  signed two's-complement byte offset.
REQ-012 Port: res_valid / res_ready  output / input  1 / 1  resolution handshake.
REQ-013 Port: res_taken  output  1, res_target  output  32, cur_flags  output  flags  (taken bit, next PC, current flags register).

Function
REQ-014 Condition codes (Z, N, V, C = flags used, REQ-016):
- 0 EQ: Z;  1 NE: !Z;  2 CS: C;  3 CC: !C
- 4 MI: N;  5 PL: !N;  6 VS: V;  7 VC: !V
- 8 HI: C&!Z;  9 LS: !C|Z;  10 GE: N==V;  11 LT: N!=V
- 12 GT: !Z&(N==V);  13 LE: Z|(N!=V);  14 AL: 1;  15 NV: 0
REQ-015 Flags register SHALL load alu_flags on every rising edge with flags_we=1 and otherwise hold; cur_flags SHALL show the register value.
REQ-016 Forwarding: a request accepted in a cycle with flags_we=1 SHALL evaluate with that cycle's alu_flags; otherwise with the flags register.
REQ-017 Accept SHALL occur on br_valid & br_ready.
- br_ready = !res_valid | res_ready (one-entry output stage, combinational backpressure).
REQ-018 Result SHALL appear on res_* the cycle after accept (latency 1).
- Full throughput of one request per cycle while res_ready=1.
REQ-019 res_target SHALL be br_pc+br_offset when taken, else br_pc+INSN_BYTES; both modulo 2^32, wrap-around silent.
REQ-020 Output state machine:
- EMPTY (res_valid=0) -> FULL on accept.
- FULL -> EMPTY on res_ready with no new accept.
- FULL -> FULL (new payload) on res_ready with a simultaneous accept.
REQ-021 While res_valid=1 and res_ready=0, res_taken/res_target SHALL hold stable and br_ready SHALL be 0.
REQ-022 The block SHALL NOT modify br_* inputs' effect after accept; later changes to the flags register SHALL NOT alter a held result.

Reset
REQ-023 On reset_n=0, without waiting for a clock edge:
- res_valid=0, res_taken=0, res_target=0.
- Flags register all zero; output state EMPTY.
REQ-024 Reset asserted mid-transaction SHALL drop the pending result with no response; the first request after reset release SHALL be accepted normally.

Verification
REQ-025 Reset then br_cond=14 (AL), br_pc=0x100, br_offset=0x20 -> next cycle res_valid=1, res_taken=1, res_target=0x120.
REQ-026 flags_we=1 with Z=1 in the same cycle as accept of EQ, pc=0x200, offset=-8 -> res_taken=1, res_target=0x1F8 (forwarding).
REQ-027 Flags register N=1, V=0, GE request, pc=0xFFFFFFFC -> res_taken=0, res_target=0x00000000 (wrap).
REQ-028 res_ready=0 for 3 cycles with br_valid=1 -> br_ready=0, res_* stable; res_ready=1 -> held result consumed and the next request accepted in the same cycle.
REQ-029 Back-to-back requests HI then LS with C=1, Z=0, res_ready=1 -> res_taken 1 then 0 on consecutive cycles.
REQ-030 reset_n pulled low while res_valid=1 -> res_valid=0 immediately and cur_flags=0.
